// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequence monitor: FSM state encoding,
// error cause codes and the table of patterns the sequencer must show.
package led_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_PATTERN = 3'd1;
   localparam logic [2:0] ERR_EARLY   = 3'd2;
   localparam logic [2:0] ERR_TIMEOUT = 3'd3;
   localparam logic [2:0] ERR_IDLE    = 3'd4;

   // Entry k is the pattern tracked while step_idx == k+1
   localparam logic [7:0][3:0] PATTERN_TABLE = {
      4'b1111, 4'b0111, 4'b0110, 4'b0101,
      4'b0100, 4'b0011, 4'b0010, 4'b0001
   };

   localparam logic [3:0] LAST_STEP = 4'd8;

   // Pattern that must follow the one tracked at the given step;
   // after the final 1111 the LEDs return to all-off
   function automatic logic [3:0] next_pattern(input logic [3:0] step);
      if (step >= 4'd1 && step <= 4'd7) begin
         return PATTERN_TABLE[step[2:0]];
      end
      return 4'b0000;
   endfunction

endpackage

// File: rtl/led_seq_monitor_dwell_timer.sv
// Dwell timer: counts how many cycles the current LED pattern has been
// held and classifies that count against the allowed dwell window.
import led_seq_pkg::*;

module dwell_timer #(
   parameter int DWELL = 67108864,
   parameter int TOL   = 0
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               clear,
   input  logic                               load,
   output logic [$clog2(DWELL+TOL+2)-1:0]     dwell,
   output logic                               early,
   output logic                               in_window,
   output logic                               timeout
);

   localparam int SAT  = DWELL + TOL + 1;
   localparam int W    = $clog2(SAT + 1);
   localparam int LOW  = (DWELL > TOL) ? (DWELL - TOL) : 0;
   localparam int HIGH = DWELL + TOL;

   localparam logic [W-1:0] LOW_V  = LOW[W-1:0];
   localparam logic [W-1:0] HIGH_V = HIGH[W-1:0];
   localparam logic [W-1:0] SAT_V  = SAT[W-1:0];
   localparam logic [W-1:0] ONE_V  = {{(W-1){1'b0}}, 1'b1};

   // Restart at 1 on a pattern change, otherwise count up and stick at the
   // saturation value so a stuck pattern can never wrap back into the window
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dwell <= '0;
      end else if (clear) begin
         dwell <= '0;
      end else if (load) begin
         dwell <= ONE_V;
      end else if (dwell != SAT_V) begin
         dwell <= dwell + ONE_V;
      end
   end

   // timeout flags the last in-window count: if the pattern does not change
   // now, the counter saturates on this same edge
   assign early     = (dwell < LOW_V);
   assign in_window = (dwell >= LOW_V) && (dwell <= HIGH_V);
   assign timeout   = (dwell >= HIGH_V);

endmodule

// File: rtl/led_seq_monitor.sv
// LED sequence monitor: watches a 4-bit LED bus, checks that the expected
// eight-pattern sequence appears with correct dwell timing, and reports
// completed sequences and the first detected error.
import led_seq_pkg::*;

module led_seq_monitor #(
   parameter int DWELL = 67108864,
   parameter int TOL   = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] led_in,
   input  logic       enable,
   input  logic       clear,
   output logic       seq_done,
   output logic       seq_err,
   output logic [2:0] err_code,
   output logic [3:0] step_idx,
   output logic [7:0] pass_cnt
);

   localparam int DWELL_W = $clog2(DWELL + TOL + 2);

   state_t               state;
   logic [3:0]           led_q;
   logic                 change;
   logic [DWELL_W-1:0]   dwell;
   logic                 early;
   logic                 in_window;
   logic                 timeout;
   logic                 timer_clear;

   // Previous-cycle copy of the LED bus used for change detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_q <= 4'b0000;
      end else begin
         led_q <= led_in;
      end
   end

   assign change      = (led_in != led_q);
   assign timer_clear = clear | ~enable;

   dwell_timer #(
      .DWELL (DWELL),
      .TOL   (TOL)
   ) u_dwell_timer (
      .clk       (clk),
      .reset     (reset),
      .clear     (timer_clear),
      .load      (change),
      .dwell     (dwell),
      .early     (early),
      .in_window (in_window),
      .timeout   (timeout)
   );

   // Sequence tracking FSM; clear beats everything, then enable, then the
   // per-state rules. err_code only latches while no error is recorded yet,
   // so it always names the first cause even across enable toggles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         seq_done <= 1'b0;
         seq_err  <= 1'b0;
         err_code <= ERR_NONE;
         step_idx <= 4'd0;
         pass_cnt <= 8'd0;
      end else begin
         seq_done <= 1'b0;
         if (clear) begin
            state    <= ST_IDLE;
            seq_err  <= 1'b0;
            err_code <= ERR_NONE;
            step_idx <= 4'd0;
         end else if (!enable) begin
            state    <= ST_IDLE;
            step_idx <= 4'd0;
         end else begin
            case (state)
               ST_IDLE: begin
                  step_idx <= 4'd0;
                  if (change) begin
                     if (led_in == PATTERN_TABLE[0]) begin
                        state    <= ST_TRACK;
                        step_idx <= 4'd1;
                     end else if (led_in != 4'b0000) begin
                        state   <= ST_ERROR;
                        seq_err <= 1'b1;
                        if (!seq_err) err_code <= ERR_IDLE;
                     end
                  end
               end
               ST_TRACK: begin
                  if (change) begin
                     if (led_in != next_pattern(step_idx)) begin
                        state   <= ST_ERROR;
                        seq_err <= 1'b1;
                        if (!seq_err) err_code <= ERR_PATTERN;
                     end else if (early || !in_window) begin
                        state   <= ST_ERROR;
                        seq_err <= 1'b1;
                        if (!seq_err) err_code <= ERR_EARLY;
                     end else if (step_idx == LAST_STEP) begin
                        state    <= ST_IDLE;
                        step_idx <= 4'd0;
                        seq_done <= 1'b1;
                        if (pass_cnt != 8'd255) pass_cnt <= pass_cnt + 8'd1;
                     end else begin
                        step_idx <= step_idx + 4'd1;
                     end
                  end else if (timeout) begin
                     state   <= ST_ERROR;
                     seq_err <= 1'b1;
                     if (!seq_err) err_code <= ERR_TIMEOUT;
                  end
               end
               ST_ERROR: begin
                  state <= ST_ERROR;
               end
               default: begin
                  state    <= ST_IDLE;
                  step_idx <= 4'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/led_seq_monitor.md
LED_SEQ_MONITOR -- requirements
Module: led_seq_monitor

Interface
REQ-001 Parameter DWELL, default 67108864, nominal cycles each pattern is held by the LED sequencer.
REQ-002 Parameter TOL, default 0, allowed +/- cycle deviation from DWELL.
REQ-003 clk  input  1  clock; reset reset, asynchronous, active-high; clock clk.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 led_in  input  4  LED pattern under observation, synchronous to clk.
REQ-006 enable  input  1  monitoring enable; low forces IDLE.
REQ-007 clear  input  1  synchronous clear of error/sticky state.
REQ-008 seq_done  output  1  one-cycle pulse on a complete, correctly timed sequence.
REQ-009 seq_err  output  1  sticky error flag.
REQ-010 err_code  output  3  cause of first error: 0 none, 1 wrong pattern, 2 early change, 3 timeout, 4 idle glitch.
REQ-011 step_idx  output  4  index of the step currently tracked (0 = idle, 1..8 = patterns 0001..0111, 1111).
REQ-012 pass_cnt  output  8  count of completed sequences, saturating at 255.

Function
REQ-013 Expected sequence: 0001, 0010, 0011, 0100, 0101, 0110, 0111, 1111, then 0000.
REQ-014 led_in is registered into led_q each cycle; a change is any cycle with led_in != led_q.
REQ-015 Dwell counter: loaded with 1 on change, else increments, saturating at DWELL+TOL+1; width is the minimum that holds DWELL+TOL+1.
REQ-016 States: IDLE, TRACK, ERROR.
REQ-017 IDLE: step_idx=0; led_in=0000 holds; change to 0001 -> TRACK, step_idx=1, dwell=1; any other nonzero value -> ERROR, code 4.
REQ-018 TRACK, on change: new value equal to next expected pattern and DWELL-TOL <= dwell <= DWELL+TOL -> step_idx+1.
REQ-019 TRACK, on change: new value not next expected -> ERROR, code 1 (takes priority over code 2).
REQ-020 TRACK, on change: expected value but dwell < DWELL-TOL -> ERROR, code 2.
REQ-021 TRACK, no change: dwell reaching DWELL+TOL+1 -> ERROR, code 3, same cycle as saturation.
REQ-022 TRACK, step_idx=8 (1111), valid change to 0000 -> seq_done high for exactly the next cycle, pass_cnt+1 (held at 255), IDLE.
REQ-023 ERROR: seq_err=1, err_code frozen at first cause, led_in ignored; exits only via clear or reset.
REQ-024 clear (any state): next cycle IDLE, seq_err=0, err_code=0, dwell cleared; pass_cnt unchanged.
REQ-025 clear and error detected in the same cycle: clear wins, no error recorded.
REQ-026 enable low: next cycle IDLE, dwell cleared, seq_done=0; seq_err, err_code, pass_cnt retained.
REQ-027 enable rising while led_in nonzero: IDLE rules apply on the first change; a steady nonzero value is not an error.

Reset
REQ-028 On reset: state IDLE, led_q=0000, dwell=0, seq_done=0, seq_err=0, err_code=0, step_idx=0, pass_cnt=0.
REQ-029 Reset mid-sequence abandons the sequence with no seq_done and no error.

Structure
REQ-030 Shared package led_seq_pkg holds the state encoding, err_code constants, and the 8-entry expected-pattern table.
REQ-031 One sub-module, dwell_timer (load/increment/saturate, exposes dwell value and the early/in-window/timeout compares); FSM and outputs stay in led_seq_monitor.

Verification (DWELL=8, TOL=0)
REQ-032 Drive 0000, then each pattern for 8 cycles through 1111, then 0000 -> seq_done one pulse, pass_cnt=1, seq_err=0.
REQ-033 Hold 0011 for 5 cycles, then 0100 -> seq_err=1, err_code=2, step_idx frozen at 3.
REQ-034 Go from 0010 after 8 cycles to 0101 -> err_code=1; assert clear -> next cycle seq_err=0, IDLE.
REQ-035 Hold 0110 with no change -> on the cycle dwell reaches 9, err_code=3; pulse 0011 after that -> err_code stays 3.
REQ-036 In IDLE drive 0100 -> err_code=4; run 256 good sequences after clear -> pass_cnt=255.
REQ-037 Assert reset at step 5 -> all outputs 0; assert clear in the error-detect cycle -> no error latched.
